tx_psf_poly: RTL

TX_PSF_POLY -- requirements
Module: tx_psf_poly

---
 rtl/tx_psf_pkg.sv | 27 ++
 rtl/tx_psf_poly_tap_sel.sv | 36 +++
 rtl/tx_psf_poly.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tx_psf_pkg.sv
// rtl/tx_psf_pkg.sv - shared constants and saturation helper for the PAM4 pulse-shaping filter
package tx_psf_pkg;

  // PAM4 symbol encoding: 0 -> -1, 1 -> -1/3, 2 -> +1/3, 3 -> +1
  localparam logic [1:0] SYM_NEG1   = 2'd0;
  localparam logic [1:0] SYM_NEG3RD = 2'd1;
  localparam logic [1:0] SYM_POS3RD = 2'd2;
  localparam logic [1:0] SYM_POS1   = 2'd3;

  localparam int CW_DEFAULT = 18;

  // Clamp a sign-extended accumulator to the signed range of a cw-bit result.
  // Returned at full width so callers can detect clipping by comparison.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] acc, input int cw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (cw - 1));
    if (acc > hi)
      saturate = hi;
    else if (acc < lo)
      saturate = lo;
    else
      saturate = acc;
  endfunction

endpackage

// File: rtl/tx_psf_poly_tap_sel.sv
// rtl/tx_psf_poly_tap_sel.sv - multiplier-less PAM4 level times coefficient for one tap
// Ports: sym/valid select the level of one delay-line entry; c_full/c_third are the
// coefficient and its precomputed third; term is the signed product at ACCW bits.
module psf_tap_sel
  import tx_psf_pkg::*;
#(
  parameter int CW   = CW_DEFAULT,
  parameter int ACCW = CW + 4
) (
  input  logic [1:0]      sym,
  input  logic            valid,
  input  logic [CW-1:0]   c_full,
  input  logic [CW-1:0]   c_third,
  output logic [ACCW-1:0] term
);

  logic [ACCW-1:0] full_x;
  logic [ACCW-1:0] third_x;

  assign full_x  = {{(ACCW-CW){c_full[CW-1]}}, c_full};
  assign third_x = {{(ACCW-CW){c_third[CW-1]}}, c_third};

  always_comb begin
    term = '0;
    if (valid) begin
      case (sym)
        SYM_POS1:   term = full_x;
        SYM_NEG1:   term = -full_x;
        SYM_POS3RD: term = third_x;
        SYM_NEG3RD: term = -third_x;
        default:    term = '0;
      endcase
    end
  end

endmodule

// File: rtl/tx_psf_poly.sv
// rtl/tx_psf_poly.sv - polyphase PAM4 transmit pulse-shaping FIR with coefficient RAM
// Ports: clk/reset (sync, active-high); samp_en output-sample strobe; sym/sym_valid/sym_ready
// symbol handshake; flush clears delay line and phase; coef_we/coef_addr/coef_wdata write
// {c_third, c_full} taps; y/y_valid filtered output; underflow/sat sticky status flags.
module tx_psf_poly
  import tx_psf_pkg::*;
#(
  parameter  int OSR   = 4,
  parameter  int SPAN  = 6,
  parameter  int CW    = CW_DEFAULT,
  localparam int NTAPS = OSR * SPAN,
  localparam int AW    = $clog2(NTAPS),
  localparam int ACCW  = CW + $clog2(SPAN) + 1,
  localparam int PW    = $clog2(OSR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          samp_en,
  input  logic [1:0]    sym,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic          flush,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [2*CW-1:0] coef_wdata,
  output logic [CW-1:0] y,
  output logic          y_valid,
  output logic          underflow,
  output logic          sat
);

  logic [PW-1:0]   phase;
  logic [SPAN-1:0] d_valid;
  logic [1:0]      d_sym       [SPAN];
  logic [CW-1:0]   c_full_mem  [NTAPS];
  logic [CW-1:0]   c_third_mem [NTAPS];
  logic [ACCW-1:0] term        [SPAN];
  logic [ACCW-1:0] term_r      [SPAN];
  logic            v1;
  logic            boundary;
  logic            coef_in_range;
  logic [ACCW-1:0] acc;
  logic signed [63:0] acc64;
  logic signed [63:0] clipped;
  logic            sat_hit;

  assign boundary      = samp_en && (phase == PW'(OSR - 1));
  assign sym_ready     = boundary && !reset && !flush;
  assign coef_in_range = ({1'b0, coef_addr} < (AW+1)'(NTAPS));

  // Tap k of the current phase reads h[phase + OSR*k]; the write port updates at the
  // edge, so a same-cycle strobe naturally sees the old coefficient.
  for (genvar k = 0; k < SPAN; k++) begin : g_tap
    logic [AW-1:0] idx;
    assign idx = AW'(phase) + AW'(OSR * k);
    psf_tap_sel #(.CW(CW), .ACCW(ACCW)) u_tap (
      .sym     (d_sym[k]),
      .valid   (d_valid[k]),
      .c_full  (c_full_mem[idx]),
      .c_third (c_third_mem[idx]),
      .term    (term[k])
    );
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < SPAN; k++)
      acc = acc + term_r[k];
    acc64   = {{(64-ACCW){acc[ACCW-1]}}, acc};
    clipped = saturate(acc64, CW);
    sat_hit = (clipped != acc64);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      d_valid   <= '0;
      v1        <= 1'b0;
      y         <= '0;
      y_valid   <= 1'b0;
      underflow <= 1'b0;
      sat       <= 1'b0;
      for (int k = 0; k < SPAN; k++) begin
        d_sym[k]  <= '0;
        term_r[k] <= '0;
      end
      for (int i = 0; i < NTAPS; i++) begin
        c_full_mem[i]  <= '0;
        c_third_mem[i] <= '0;
      end
    end else begin
      if (coef_we && coef_in_range) begin
        c_full_mem[coef_addr]  <= coef_wdata[CW-1:0];
        c_third_mem[coef_addr] <= coef_wdata[2*CW-1:CW];
      end

      // Stage 1 captures the selected terms; stage 2 sums and clamps.
      v1 <= samp_en;
      if (samp_en)
        for (int k = 0; k < SPAN; k++)
          term_r[k] <= term[k];

      y_valid <= v1;
      if (v1) begin
        y <= clipped[CW-1:0];
        if (sat_hit)
          sat <= 1'b1;
      end

      // Flush wins over the symbol boundary; in-flight pipeline stages are left alone.
      if (flush) begin
        phase   <= '0;
        d_valid <= '0;
      end else if (samp_en) begin
        phase <= boundary ? '0 : phase + 1'b1;
        if (boundary) begin
          for (int k = SPAN - 1; k > 0; k--) begin
            d_valid[k] <= d_valid[k-1];
            d_sym[k]   <= d_sym[k-1];
          end
          d_valid[0] <= sym_valid;
          d_sym[0]   <= sym;
          if (!sym_valid)
            underflow <= 1'b1;
        end
      end
    end
  end

endmodule
